lsu_sq: RTL and testbench

LSU_SQ -- requirements
Module: lsu_sq

---
 rtl/lsu_sq_if.sv | 43 ++++
 rtl/lsu_sq.sv | 138 +++++++++++++
 tb/tb_lsu_sq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_sq_if.sv
// Handshake bundle between LSU_ID / ROB / LSU_EX / LQ and the store queue.
// The store queue uses the slave view; the surrounding pipeline uses master.
interface lsu_sq_if #(
  parameter int ROB_TAG_WIDTH = 6
) ();
  logic                     i_flush;
  logic                     o_full;
  logic                     i_alloc_en;
  logic [ROB_TAG_WIDTH-1:0] i_alloc_tag;
  logic [31:0]              i_alloc_addr;
  logic [31:0]              i_alloc_data;
  logic [3:0]               i_alloc_lsu_func;
  logic                     i_rob_retire_en;
  logic [ROB_TAG_WIDTH-1:0] i_rob_retire_tag;
  logic                     i_retire_stall;
  logic                     o_retire_en;
  logic [31:0]              o_retire_addr;
  logic [31:0]              o_retire_data;
  logic [3:0]               o_retire_lsu_func;
  logic [ROB_TAG_WIDTH-1:0] o_retire_tag;
  logic                     i_update_en;
  logic                     i_update_retry;
  logic                     i_mhq_fill;
  logic                     o_lq_retire_en;
  logic [31:0]              o_lq_retire_addr;
  logic [3:0]               o_lq_retire_lsu_func;

  modport slave (
    input  i_flush, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_lsu_func,
           i_rob_retire_en, i_rob_retire_tag, i_retire_stall, i_update_en, i_update_retry,
           i_mhq_fill,
    output o_full, o_retire_en, o_retire_addr, o_retire_data, o_retire_lsu_func, o_retire_tag,
           o_lq_retire_en, o_lq_retire_addr, o_lq_retire_lsu_func
  );

  modport master (
    output i_flush, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_lsu_func,
           i_rob_retire_en, i_rob_retire_tag, i_retire_stall, i_update_en, i_update_retry,
           i_mhq_fill,
    input  o_full, o_retire_en, o_retire_addr, o_retire_data, o_retire_lsu_func, o_retire_tag,
           o_lq_retire_en, o_lq_retire_addr, o_lq_retire_lsu_func
  );
endinterface

// File: rtl/lsu_sq.sv
// In-order store queue: circular FIFO of stores that issue to LSU_EX only once
// ROB-retired, one at a time from the head, with MHQ-full retry support.
module lsu_sq #(
  parameter int SQ_DEPTH      = 8,
  parameter int SQ_TAG_WIDTH  = 3,
  parameter int ROB_TAG_WIDTH = 6
) (
  input  logic     clk,
  input  logic     n_rst,
  lsu_sq_if.slave  sq
);
  localparam int CW = SQ_TAG_WIDTH + 1;
  typedef logic [SQ_TAG_WIDTH-1:0] ptr_t;

  logic [SQ_DEPTH-1:0]      valid_q, valid_d, retired_q, retired_d;
  logic [SQ_DEPTH-1:0]      inflight_q, inflight_d, wait_q, wait_d, ret_now;
  logic [ROB_TAG_WIDTH-1:0] tag_q  [SQ_DEPTH];
  logic [31:0]              addr_q [SQ_DEPTH];
  logic [31:0]              data_q [SQ_DEPTH];
  logic [3:0]               func_q [SQ_DEPTH];
  ptr_t                     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d, nret;
  logic                     lq_en_q, lq_en_d;
  logic [31:0]              lq_addr_q, lq_addr_d;
  logic [3:0]               lq_func_q, lq_func_d;
  logic                     alloc_ok, issue, free_head, retry_head;

  assign sq.o_full           = (count_q == CW'(SQ_DEPTH));
  assign alloc_ok            = sq.i_alloc_en & ~sq.o_full & ~sq.i_flush;
  assign free_head           = sq.i_update_en & ~sq.i_update_retry;
  assign retry_head          = sq.i_update_en & sq.i_update_retry;
  assign issue               = valid_q[head_q] & retired_q[head_q] & ~inflight_q[head_q]
                             & ~wait_q[head_q] & ~sq.i_retire_stall;
  assign sq.o_retire_en      = issue;
  assign sq.o_retire_addr    = addr_q[head_q];
  assign sq.o_retire_data    = data_q[head_q];
  assign sq.o_retire_lsu_func = func_q[head_q];
  assign sq.o_retire_tag     = tag_q[head_q];
  assign sq.o_lq_retire_en   = lq_en_q;
  assign sq.o_lq_retire_addr = lq_addr_q;
  assign sq.o_lq_retire_lsu_func = lq_func_q;

  // Retired set including this cycle's ROB commit; a flush keeps exactly these.
  always_comb begin
    nret = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      ret_now[i] = retired_q[i] | (sq.i_rob_retire_en & valid_q[i] &
                                   (tag_q[i] == sq.i_rob_retire_tag));
      nret = nret + CW'(valid_q[i] & ret_now[i]);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    retired_d  = ret_now;
    inflight_d = inflight_q;
    wait_d     = wait_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    lq_en_d    = 1'b0;
    lq_addr_d  = lq_addr_q;
    lq_func_d  = lq_func_q;
    if (issue) inflight_d[head_q] = 1'b1;
    // A fill only wakes a store already waiting; a retry arriving with it wins.
    if (sq.i_mhq_fill && wait_q[head_q]) wait_d[head_q] = 1'b0;
    if (retry_head) begin
      inflight_d[head_q] = 1'b0;
      wait_d[head_q]     = 1'b1;
    end
    if (free_head) begin
      valid_d[head_q]    = 1'b0;
      retired_d[head_q]  = 1'b0;
      inflight_d[head_q] = 1'b0;
      wait_d[head_q]     = 1'b0;
      head_d             = head_q + ptr_t'(1);
      lq_en_d            = 1'b1;
      lq_addr_d          = addr_q[head_q];
      lq_func_d          = func_q[head_q];
    end
    if (sq.i_flush) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (!ret_now[i]) begin
          valid_d[i]    = 1'b0;
          inflight_d[i] = 1'b0;
          wait_d[i]     = 1'b0;
        end
      end
      tail_d  = head_q + ptr_t'(nret);
      count_d = nret - CW'(free_head);
    end else begin
      count_d = count_q + CW'(alloc_ok) - CW'(free_head);
      if (alloc_ok) begin
        valid_d[tail_q]    = 1'b1;
        retired_d[tail_q]  = 1'b0;
        inflight_d[tail_q] = 1'b0;
        wait_d[tail_q]     = 1'b0;
        tail_d             = tail_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q    <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      wait_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      lq_en_q    <= 1'b0;
      lq_addr_q  <= '0;
      lq_func_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
      wait_q     <= wait_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      lq_en_q    <= lq_en_d;
      lq_addr_q  <= lq_addr_d;
      lq_func_q  <= lq_func_d;
    end
  end

  // Payload storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      tag_q[tail_q]  <= sq.i_alloc_tag;
      addr_q[tail_q] <= sq.i_alloc_addr;
      data_q[tail_q] <= sq.i_alloc_data;
      func_q[tail_q] <= sq.i_alloc_lsu_func;
    end
  end
endmodule

// File: tb/tb_lsu_sq.sv
// Directed bench for lsu_sq: issue/complete, full drop, retry/fill, flush,
// mid-flight reset and pointer wrap, checked with immediate assertions.
module tb_lsu_sq;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lsu_sq_if #(.ROB_TAG_WIDTH(6)) sif ();
  lsu_sq #(.SQ_DEPTH(8), .SQ_TAG_WIDTH(3), .ROB_TAG_WIDTH(6)) dut (
    .clk(clk), .n_rst(n_rst), .sq(sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    sif.i_flush = 0; sif.i_alloc_en = 0; sif.i_alloc_tag = '0; sif.i_alloc_addr = '0;
    sif.i_alloc_data = '0; sif.i_alloc_lsu_func = '0; sif.i_rob_retire_en = 0;
    sif.i_rob_retire_tag = '0; sif.i_retire_stall = 0; sif.i_update_en = 0;
    sif.i_update_retry = 0; sif.i_mhq_fill = 0;
  endtask

  task automatic alloc(input int tag, input logic [31:0] addr);
    sif.i_alloc_en = 1; sif.i_alloc_tag = 6'(tag); sif.i_alloc_addr = addr;
    sif.i_alloc_data = ~addr; sif.i_alloc_lsu_func = 4'h2;
    tick();
    sif.i_alloc_en = 0;
  endtask

  task automatic rob_retire(input int tag);
    sif.i_rob_retire_en = 1; sif.i_rob_retire_tag = 6'(tag);
    tick();
    sif.i_rob_retire_en = 0;
  endtask

  // Optionally ROB-retire, then issue the head and complete it without retry.
  task automatic run_head(input bit do_ret, input int tag, input logic [31:0] addr);
    if (do_ret) rob_retire(tag);
    chk("issue_en", sif.o_retire_en, 1);
    chk("issue_addr", sif.o_retire_addr, addr);
    tick();
    chk("inflight_no_reissue", sif.o_retire_en, 0);
    sif.i_update_en = 1; sif.i_update_retry = 0;
    tick();
    sif.i_update_en = 0;
    chk("lq_en", sif.o_lq_retire_en, 1);
    chk("lq_addr", sif.o_lq_retire_addr, addr);
  endtask

  initial begin
    idle();
    tick(); tick();
    chk("rst_full", sif.o_full, 0);
    chk("rst_retire_en", sif.o_retire_en, 0);
    chk("rst_lq_en", sif.o_lq_retire_en, 0);
    chk("rst_count", dut.count_q, 0);
    n_rst = 1;
    tick();

    // Basic store: alloc, stall holds issue, retire, complete.
    alloc(5, 32'h100);
    chk("s1_count1", dut.count_q, 1);
    chk("s1_not_retired", sif.o_retire_en, 0);
    sif.i_retire_stall = 1;
    rob_retire(5);
    chk("s1_stall", sif.o_retire_en, 0);
    sif.i_retire_stall = 0; #1;
    chk("s1_tag", sif.o_retire_tag, 5);
    chk("s1_data", sif.o_retire_data, ~32'h100);
    chk("s1_func", sif.o_retire_lsu_func, 4'h2);
    run_head(0, 5, 32'h100);
    chk("s1_lq_func", sif.o_lq_retire_lsu_func, 4'h2);
    chk("s1_count0", dut.count_q, 0);
    tick();
    chk("s1_lq_one_cycle", sif.o_lq_retire_en, 0);

    // Full: head=tail=1 here; 9th alloc dropped even when a slot frees.
    for (int i = 0; i < 8; i++) alloc(i, 32'h200 + 32'(i * 4));
    chk("s2_full", sif.o_full, 1);
    alloc(8, 32'h300);
    chk("s2_drop_count", dut.count_q, 8);
    rob_retire(0);
    tick();
    sif.i_alloc_en = 1; sif.i_alloc_tag = 6'd8; sif.i_alloc_addr = 32'h300;
    sif.i_update_en = 1; sif.i_update_retry = 0;
    tick();
    sif.i_alloc_en = 0; sif.i_update_en = 0;
    chk("s2_count7", dut.count_q, 7);
    chk("s2_tail", dut.tail_q, 1);
    chk("s2_lq_addr", sif.o_lq_retire_addr, 32'h200);
    chk("s2_not_full", sif.o_full, 0);
    for (int i = 1; i < 8; i++) run_head(1, i, 32'h200 + 32'(i * 4));
    chk("s2_empty", dut.count_q, 0);

    // Retry: fill with the retry is ignored, a later fill reissues.
    alloc(10, 32'h380);
    rob_retire(10);
    chk("s3_issue", sif.o_retire_en, 1);
    tick();
    sif.i_update_en = 1; sif.i_update_retry = 1; sif.i_mhq_fill = 1;
    tick();
    sif.i_update_en = 0; sif.i_update_retry = 0; sif.i_mhq_fill = 0;
    chk("s3_wait_same_fill", sif.o_retire_en, 0);
    tick();
    chk("s3_still_wait", sif.o_retire_en, 0);
    sif.i_mhq_fill = 1;
    tick();
    sif.i_mhq_fill = 0;
    run_head(0, 10, 32'h380);

    // Flush: head=2; 4 allocs, two retired, stall holds issue.
    sif.i_retire_stall = 1;
    for (int i = 0; i < 4; i++) alloc(20 + i, 32'h400 + 32'(i * 4));
    rob_retire(20);
    rob_retire(21);
    sif.i_flush = 1;
    tick();
    sif.i_flush = 0;
    chk("s4_count2", dut.count_q, 2);
    chk("s4_tail", dut.tail_q, 4);
    sif.i_retire_stall = 0; #1;
    run_head(0, 20, 32'h400);
    run_head(0, 21, 32'h404);
    chk("s4_drained", dut.count_q, 0);
    alloc(30, 32'h500);
    chk("s4_new_slot", dut.addr_q[4], 32'h500);
    chk("s4_tail_after", dut.tail_q, 5);
    run_head(1, 30, 32'h500);

    // Reset while a store is in flight.
    alloc(40, 32'h600);
    rob_retire(40);
    tick();
    n_rst = 0; #1;
    chk("s5_retire_en", sif.o_retire_en, 0);
    chk("s5_full", sif.o_full, 0);
    chk("s5_lq_en", sif.o_lq_retire_en, 0);
    chk("s5_count", dut.count_q, 0);
    #1 n_rst = 1;
    tick(); tick();
    chk("s5_no_lq_after", sif.o_lq_retire_en, 0);
    chk("s5_no_issue_after", sif.o_retire_en, 0);

    // Wrap: three stores ahead, 20 alloc/complete pairs crossing the wrap.
    for (int i = 0; i < 3; i++) alloc(i, 32'h1000 + 32'(i * 16));
    for (int i = 0; i < 20; i++) begin
      if (i + 3 < 20) alloc(i + 3, 32'h1000 + 32'((i + 3) * 16));
      run_head(1, i, 32'h1000 + 32'(i * 16));
    end
    chk("s6_empty", dut.count_q, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
